// File: rtl/encoder_8x3_seq_pkg.sv
// rtl/encoder_8x3_seq_pkg.sv - shared widths, state enum and vector types for the 8-to-3 encoder
package encoder_pkg;

    localparam int VEC_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } enc_state_t;

    typedef logic [VEC_W-1:0] vec_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/encoder_8x3_seq_if.sv
// rtl/encoder_8x3_seq_if.sv - request and index-beat handshake bundle for the encoder
interface encoder_8x3_seq_if;
    import encoder_pkg::*;

    vec_t in;
    logic in_valid;
    logic in_ready;
    idx_t out;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic zero_err;

    // slave is the encoder itself; master is whoever feeds vectors and drains beats
    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, out_last, zero_err
    );

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, out_last, zero_err
    );

endinterface

// File: rtl/encoder_8x3_seq_prio_enc.sv
// rtl/encoder_8x3_seq_prio_enc.sv - combinational priority encoder picking the next set bit of a vector
module prio_enc_8x3
    import encoder_pkg::*;
(
    input  vec_t vec,
    input  logic msb_first,
    output idx_t idx,
    output vec_t onehot,
    output logic single
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        if (msb_first) begin
            for (int i = VEC_W - 1; i >= 0; i--) begin
                if (vec[i] && !found) begin
                    idx   = idx_t'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < VEC_W; i++) begin
                if (vec[i] && !found) begin
                    idx   = idx_t'(i);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        onehot = found ? (vec_t'(1) << idx) : '0;
        // clearing the lowest set bit leaves zero only when exactly one bit was set
        single = found && ((vec & (vec - vec_t'(1))) == '0);
    end

endmodule

// File: rtl/encoder_8x3_seq.sv
// rtl/encoder_8x3_seq.sv - serialises a multi-hot request vector into one 3-bit index per beat
module encoder_8x3_seq
    import encoder_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    encoder_8x3_seq_if.slave   bus
);

    enc_state_t state_q, state_d;
    vec_t       pending_q, pending_d;
    logic       zero_err_q, zero_err_d;

    idx_t sel_idx;
    vec_t sel_onehot;
    logic sel_single;
    logic accept;

    prio_enc_8x3 u_prio (
        .vec       (pending_q),
        .msb_first (MSB_FIRST),
        .idx       (sel_idx),
        .onehot    (sel_onehot),
        .single    (sel_single)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            zero_err_q <= zero_err_d;
        end
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in != '0) begin
                        pending_d = bus.in;
                        state_d   = BUSY;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus.out_ready) begin
                    pending_d = pending_q & ~sel_onehot;
                    if (sel_single) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // beats come straight from registered pending, so in never reaches out combinationally
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == BUSY);
        bus.out       = (state_q == BUSY) ? sel_idx : '0;
        bus.out_last  = (state_q == BUSY) && sel_single;
        bus.zero_err  = zero_err_q;
    end

endmodule

// File: doc/encoder_8x3_seq.md
# encoder_8x3_seq

Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 decoder. It accepts an 8-bit request vector through a valid/ready handshake and emits the 3-bit index of every set bit, one index per output beat. Order is lowest index first by default. It sits upstream of the decoder so that a multi-hot request word can be serialised into one-hot selects.

## Interface
Parameters:
- MSB_FIRST, default 0: 0 = emit lowest set index first; 1 = emit highest set index first.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in, input, 8: request vector; sampled only on an accept.
- in_valid, input, 1: `in` is valid.
- in_ready, output, 1: block can accept a vector.
- out, output, 3: encoded index of the current set bit.
- out_valid, output, 1: `out` and `out_last` are valid.
- out_ready, input, 1: downstream consumes the current beat.
- out_last, output, 1: current beat is the final index of this vector.
- zero_err, output, 1: one-cycle pulse; an all-zero vector was accepted and dropped.

## Operation
- State machine has two states, IDLE and BUSY. Reset enters IDLE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - Accept occurs when in_valid & in_ready.
  - If the accepted `in` is nonzero: pending <= in, go to BUSY.
  - If the accepted `in` is 8'h00: pending is unchanged, stay in IDLE, zero_err = 1 on the next cycle.
- BUSY:
  - in_ready = 0, out_valid = 1.
  - out = index of the lowest set bit of pending (highest if MSB_FIRST = 1).
  - out_last = 1 when exactly one bit of pending is set.
  - On out_valid & out_ready, that bit is cleared in pending.
  - If that beat had out_last = 1, go to IDLE; otherwise stay in BUSY.
- Without out_ready, out/out_valid/out_last hold stable; pending is unchanged (AXI-style: no retraction, no change while stalled).
- Number of beats per vector equals popcount(in), in the range 1..8. out width is fixed at 3 bits; index 7 maps to 3'b111.
- zero_err is registered, high for exactly one cycle per dropped zero vector.
- Reset mid-operation: pending <= 0, state <= IDLE. The partially emitted vector is lost; no out_last is emitted.

## Timing
- Reset values: in_ready = 1 (held at 0 while rst is asserted), out = 3'b000, out_valid = 0, out_last = 0, zero_err = 0.
- Latency: accept in cycle N gives the first out_valid in cycle N+1.
- Throughput: one index per cycle while out_ready = 1.
- A vector with k set bits, with no stalls, occupies cycles N+1..N+k. in_ready returns to 1 in cycle N+k+1.
- No overlap: the next vector can be accepted no earlier than cycle N+k+1. Idle gap per vector is one cycle.
- out and out_last are decoded from registered pending; there is no combinational path from `in` to `out`.
- in_ready depends on state only; there is no combinational path from out_ready to in_ready.

## Structure
- Package encoder_pkg holds:
  - localparam VEC_W = 8, IDX_W = 3.
  - typedef enum logic {IDLE, BUSY} enc_state_t.
  - typedef logic [VEC_W-1:0] vec_t and logic [IDX_W-1:0] idx_t.
- Sub-module prio_enc_8x3 (combinational):
  - Inputs: vec (8 bits), msb_first (1 bit).
  - Outputs: idx (3 bits), onehot (8 bits, the selected bit, used to clear pending), single (exactly one bit set).
  - Instantiated once on pending.
- Top level holds the state register, pending register, zero_err register and handshake logic.

## Test plan
- Reset then 8'b1010_0100 with out_ready = 1 → beats 2, 5, 7 on consecutive cycles; out_last only on 7; in_ready = 1 on the following cycle.
- MSB_FIRST = 1, in = 8'hFF → beats 7,6,5,4,3,2,1,0; out_last only on 0; 8 beats total.
- in = 8'h00 accepted → no out_valid, zero_err pulses for one cycle, in_ready stays 1.
- in = 8'b0001_0010, out_ready low for 3 cycles on the first beat → out holds 1 for all stall cycles, then beats 1, 4; no index lost or duplicated.
- rst asserted for one cycle after the first beat of 8'hC3 → out_valid = 0 the next cycle, state IDLE; a following in = 8'h08 yields a single beat 3 with out_last = 1.
- Back-to-back in_valid held high with in = 8'h01, then 8'h80 → beats 0 (last), one idle cycle, then 7 (last).
